lock_code_sender: RTL and testbench

Sequencer that drives the combination-lock entry port from the user side. On a start request it latches a multi-digit code, clears the lock with a one-cycle reset pulse, and presents the digits back-to-back with the enable strobe. It then watches the lock's unlock output and reports success, or retries up to a bounded count and reports failure. It sits between a control/test host and the lock's `X`/`e`/`r` inputs.

---
 rtl/lock_code_sender.sv | 122 ++++++++++++
 tb/tb_lock_code_sender.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_code_sender.sv
// Drives a combination lock: on start, latches the code, pulses lock_r, streams N digits, then awaits L (with retries).
// Latency: lock_r in the cycle after start; done at start+N+3 on success; each failed attempt costs 1+N+TIMEOUT cycles.
// No backpressure: start is only sampled in IDLE and digits stream back-to-back, since the lock has no ready.
module lock_code_sender #(
    parameter int W         = 3,
    parameter int N         = 3,
    parameter int TIMEOUT   = 8,
    parameter int MAX_TRIES = 2
) (
    input  logic           clk,
    input  logic           r,
    input  logic           start,
    input  logic [N*W-1:0] code,
    input  logic           L,
    output logic [W-1:0]   X,
    output logic           e,
    output logic           lock_r,
    output logic           busy,
    output logic           done,
    output logic           fail
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int AW = $clog2(MAX_TRIES + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_TRIES);

    typedef enum logic [2:0] {IDLE, CLR, SEND, WAIT, DONE, FAIL} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [TW-1:0]    cnt, cnt_nxt;
    logic [AW-1:0]    att, att_nxt;
    logic [N*W-1:0]   code_q, code_nxt;

    // Digit 0 sits in the most significant slice of the code.
    function automatic logic [W-1:0] digit_at(input logic [N*W-1:0] c, input logic [IW-1:0] i);
        logic [W-1:0] d;
        d = '0;
        for (int k = 0; k < N; k++) begin
            if (i == IW'(k)) d = c[(N-1-k)*W +: W];
        end
        return d;
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        att_nxt   = att;
        code_nxt  = code_q;
        case (state)
            IDLE: begin
                if (start) begin
                    code_nxt  = code;
                    att_nxt   = AW'(1);
                    state_nxt = CLR;
                end
            end
            CLR: begin
                idx_nxt   = '0;
                state_nxt = SEND;
            end
            SEND: begin
                if (idx == IDX_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            WAIT: begin
                // An unlock seen on the final window cycle still counts as success.
                if (L) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    if (att < ATT_MAX) begin
                        att_nxt   = att + AW'(1);
                        state_nxt = CLR;
                    end else begin
                        state_nxt = FAIL;
                    end
                end else begin
                    cnt_nxt = cnt + TW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            FAIL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            att    <= '0;
            code_q <= '0;
            X      <= '0;
            e      <= 1'b0;
            lock_r <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            fail   <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            att    <= att_nxt;
            code_q <= code_nxt;
            X      <= (state_nxt == SEND) ? digit_at(code_q, idx_nxt) : '0;
            e      <= (state_nxt == SEND);
            lock_r <= (state_nxt == CLR);
            busy   <= (state_nxt != IDLE);
            done   <= (state_nxt == DONE);
            fail   <= (state_nxt == FAIL);
        end
    end
endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender: default-parameter instance against a small lock model, plus an N=1/TIMEOUT=1/MAX_TRIES=1 instance.
module tb_lock_code_sender;
    localparam logic [1:0] K_CLR = 2'd0, K_DIG = 2'd1, K_DONE = 2'd2, K_FAIL = 2'd3;
    localparam logic [8:0] GOOD = 9'b101_011_101;
    localparam logic [8:0] BAD  = 9'b101_011_111;

    typedef struct packed {
        logic        dut;
        logic [1:0]  kind;
        logic [2:0]  val;
        logic [31:0] cyc;
    } evt_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r, start_a, start_b, l_a;
    logic [8:0] code_a;
    logic [2:0] code_b;
    logic [2:0] x_a, x_b;
    logic       e_a, lock_r_a, busy_a, done_a, fail_a;
    logic       e_b, lock_r_b, busy_b, done_b, fail_b;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    evt_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    lock_code_sender dut_a (
        .clk(clk), .r(r), .start(start_a), .code(code_a), .L(l_a),
        .X(x_a), .e(e_a), .lock_r(lock_r_a), .busy(busy_a), .done(done_a), .fail(fail_a)
    );

    lock_code_sender #(.W(3), .N(1), .TIMEOUT(1), .MAX_TRIES(1)) dut_b (
        .clk(clk), .r(r), .start(start_b), .code(code_b), .L(1'b0),
        .X(x_b), .e(e_b), .lock_r(lock_r_b), .busy(busy_b), .done(done_b), .fail(fail_b)
    );

    // Lock model: secret 5,3,5; opens on the edge ending the last correct digit; e low mid-sequence drops progress.
    logic [2:0] secret [3];
    int         prog = 0;
    logic       open_q = 1'b0;
    logic       l_force = 1'b0;
    assign secret[0] = 3'd5;
    assign secret[1] = 3'd3;
    assign secret[2] = 3'd5;
    assign l_a = open_q | l_force;

    always @(posedge clk) begin
        if (lock_r_a) begin
            prog   <= 0;
            open_q <= 1'b0;
        end else if (!open_q) begin
            if (e_a) begin
                if (x_a == secret[prog]) begin
                    if (prog == 2) begin
                        open_q <= 1'b1;
                        prog   <= 0;
                    end else begin
                        prog <= prog + 1;
                    end
                end else begin
                    prog <= (x_a == secret[0]) ? 1 : 0;
                end
            end else begin
                prog <= 0;
            end
        end
    end

    function automatic evt_t mk(input logic d, input logic [1:0] k, input logic [2:0] v, input int c);
        evt_t ev;
        ev.dut  = d;
        ev.kind = k;
        ev.val  = v;
        ev.cyc  = 32'(c);
        return ev;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic d, input logic [1:0] k, input logic [2:0] v, input int c);
        q.push_back(mk(d, k, v, c));
    endtask

    task automatic push_seq_a(input int t0, input logic [8:0] c);
        push(1'b0, K_CLR, 3'd0, t0 + 1);
        push(1'b0, K_DIG, c[8:6], t0 + 2);
        push(1'b0, K_DIG, c[5:3], t0 + 3);
        push(1'b0, K_DIG, c[2:0], t0 + 4);
    endtask

    task automatic take(input evt_t act);
        evt_t ex;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL evt_unexpected: got dut%0d kind%0d val%0d cyc%0d, expected no event",
                     act.dut, act.kind, act.val, act.cyc);
        end else begin
            ex = q.pop_front();
            if (act !== ex) begin
                n_bad++;
                $display("FAIL evt: got dut%0d kind%0d val%0d cyc%0d, expected dut%0d kind%0d val%0d cyc%0d",
                         act.dut, act.kind, act.val, act.cyc, ex.dut, ex.kind, ex.val, ex.cyc);
            end
        end
    endtask

    // Monitor: every strobe the DUTs present is matched against the next expected event.
    always @(negedge clk) begin
        if (lock_r_a) take(mk(1'b0, K_CLR, 3'd0, cyc));
        if (e_a)      take(mk(1'b0, K_DIG, x_a, cyc));
        if (done_a)   take(mk(1'b0, K_DONE, 3'd0, cyc));
        if (fail_a)   take(mk(1'b0, K_FAIL, 3'd0, cyc));
        if (lock_r_b) take(mk(1'b1, K_CLR, 3'd0, cyc));
        if (e_b)      take(mk(1'b1, K_DIG, x_b, cyc));
        if (done_b)   take(mk(1'b1, K_DONE, 3'd0, cyc));
        if (fail_b)   take(mk(1'b1, K_FAIL, 3'd0, cyc));
    end

    task automatic check_a_zero(input string tag);
        chk({tag, "_X"},      int'(x_a), 0);
        chk({tag, "_e"},      int'(e_a), 0);
        chk({tag, "_lock_r"}, int'(lock_r_a), 0);
        chk({tag, "_busy"},   int'(busy_a), 0);
        chk({tag, "_done"},   int'(done_a), 0);
        chk({tag, "_fail"},   int'(fail_a), 0);
    endtask

    initial begin
        int t;
        r = 1'b0; start_a = 1'b0; start_b = 1'b0; code_a = '0; code_b = '0;
        #2;
        check_a_zero("rst");
        chk("rst_b_busy", int'(busy_b), 0);
        chk("rst_b_fail", int'(fail_b), 0);
        chk("rst_b_X",    int'(x_b), 0);
        @(negedge clk);
        r = 1'b1;
        repeat (2) @(negedge clk);

        // Correct code: lock_r t+1, digits 5,3,5 at t+2..t+4, done t+6, busy t+1..t+6.
        t = cyc;
        push_seq_a(t, GOOD);
        push(1'b0, K_DONE, 3'd0, t + 6);
        start_a = 1'b1; code_a = GOOD;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) @(negedge clk);
            chk("busy_window", int'(busy_a), (k <= 6) ? 1 : 0);
        end
        repeat (3) @(negedge clk);

        // Wrong code: two attempts of 12 cycles each, fail at t+25.
        t = cyc;
        push_seq_a(t, BAD);
        push_seq_a(t + 12, BAD);
        push(1'b0, K_FAIL, 3'd0, t + 25);
        start_a = 1'b1; code_a = BAD;
        @(negedge clk);
        start_a = 1'b0;
        repeat (28) @(negedge clk);

        // start held and code toggled: latched code used, then restart accepted in the IDLE cycle t+7.
        t = cyc;
        push_seq_a(t, GOOD);
        push(1'b0, K_DONE, 3'd0, t + 6);
        push_seq_a(t + 7, GOOD);
        push(1'b0, K_DONE, 3'd0, t + 13);
        start_a = 1'b1; code_a = GOOD;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            code_a = (k % 2 == 1) ? ~GOOD : GOOD;
        end
        @(negedge clk);
        code_a = GOOD;
        @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);

        // Async reset while digit 2 is on the port: outputs clear without a clock edge.
        t = cyc;
        push(1'b0, K_CLR, 3'd0, t + 1);
        push(1'b0, K_DIG, 3'd5, t + 2);
        push(1'b0, K_DIG, 3'd3, t + 3);
        start_a = 1'b1; code_a = GOOD;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 r = 1'b0;
        #1 check_a_zero("async");
        repeat (2) @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        t = cyc;
        push_seq_a(t, GOOD);
        push(1'b0, K_DONE, 3'd0, t + 6);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);

        // L only in the last WAIT cycle (t+12) of attempt 1: done at t+13, no retry.
        t = cyc;
        push_seq_a(t, BAD);
        push(1'b0, K_DONE, 3'd0, t + 13);
        start_a = 1'b1; code_a = BAD;
        @(negedge clk);
        start_a = 1'b0;
        repeat (11) @(negedge clk);
        l_force = 1'b1;
        @(negedge clk);
        l_force = 1'b0;
        repeat (16) @(negedge clk);

        // Boundary instance: CLR, one digit, one WAIT cycle, fail at t+4.
        t = cyc;
        push(1'b1, K_CLR, 3'd0, t + 1);
        push(1'b1, K_DIG, 3'd6, t + 2);
        push(1'b1, K_FAIL, 3'd0, t + 4);
        start_b = 1'b1; code_b = 3'b110;
        @(negedge clk);
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("b_busy_at_fail", int'(busy_b), 1);
        @(negedge clk);
        chk("b_busy_after", int'(busy_b), 0);
        repeat (3) @(negedge clk);

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
